vga_text_console_writer: RTL and testbench

//  Avalon-MM master that drives the 80x30 VGA text-mode VRAM slave from a character stream.

---
 rtl/vga_text_console_writer.sv | 147 ++++++++++++++
 tb/tb_vga_text_console_writer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_console_writer.sv
// Avalon-MM write master for the 80x30 text-mode VRAM: turns a character stream into
// byte-lane writes at a hardware cursor, and runs a full VRAM clear plus control-register init.
module vga_text_console_writer #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 30,
    parameter int unsigned VRAM_WORDS = 600,
    parameter int unsigned CTRL_ADDR  = 600,
    parameter logic [31:0] CTRL_INIT  = 32'h01E00000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  CHAR_IN,
    input  logic        CHAR_INV,
    input  logic        CHAR_VALID,
    output logic        CHAR_READY,
    input  logic        CLEAR_REQ,
    output logic        BUSY,
    output logic [6:0]  CURSOR_COL,
    output logic [4:0]  CURSOR_ROW,
    output logic [9:0]  AVM_ADDR,
    output logic        AVM_CS,
    output logic        AVM_WRITE,
    output logic [3:0]  AVM_BYTE_EN,
    output logic [31:0] AVM_WRITEDATA,
    input  logic        AVM_WAITREQUEST
);
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned IDX_W  = 12;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CHAR_WR = 2'd1;
    localparam logic [1:0] ST_CLR_WR  = 2'd2;
    localparam logic [1:0] ST_CTRL_WR = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [COL_W-1:0]  col_nxt;
    logic [ROW_W-1:0]  row_nxt, row_inc;
    logic [ADDR_W-1:0] addr_nxt;
    logic [3:0]        be_nxt;
    logic [31:0]       wdata_nxt;
    logic              write_nxt;
    logic [IDX_W-1:0]  idx;

    assign CHAR_READY = (state == ST_IDLE) & ~CLEAR_REQ;
    assign AVM_CS     = AVM_WRITE;

    assign row_inc = (CURSOR_ROW == ROW_W'(ROWS - 1)) ? '0 : CURSOR_ROW + ROW_W'(1);
    assign idx     = IDX_W'(CURSOR_ROW) * IDX_W'(COLS) + IDX_W'(CURSOR_COL);

    // Next-state, cursor and bus-output decode; bus fields hold while the slave stalls.
    always_comb begin
        state_nxt = state;
        col_nxt   = CURSOR_COL;
        row_nxt   = CURSOR_ROW;
        addr_nxt  = AVM_ADDR;
        be_nxt    = AVM_BYTE_EN;
        wdata_nxt = AVM_WRITEDATA;
        write_nxt = AVM_WRITE;
        case (state)
            ST_IDLE: begin
                if (CLEAR_REQ) begin
                    state_nxt = ST_CLR_WR;
                    write_nxt = 1'b1;
                    addr_nxt  = '0;
                    be_nxt    = 4'hF;
                    wdata_nxt = '0;
                end else if (CHAR_VALID) begin
                    case (CHAR_IN)
                        8'h0A: begin
                            col_nxt = '0;
                            row_nxt = row_inc;
                        end
                        8'h0D: col_nxt = '0;
                        8'h08: if (CURSOR_COL != '0) col_nxt = CURSOR_COL - COL_W'(1);
                        default: begin
                            state_nxt = ST_CHAR_WR;
                            write_nxt = 1'b1;
                            addr_nxt  = idx[11:2];
                            be_nxt    = 4'(4'b0001 << idx[1:0]);
                            wdata_nxt = {4{CHAR_INV, CHAR_IN[6:0]}};
                        end
                    endcase
                end
            end
            ST_CHAR_WR: begin
                if (!AVM_WAITREQUEST) begin
                    state_nxt = ST_IDLE;
                    write_nxt = 1'b0;
                    if (CURSOR_COL == COL_W'(COLS - 1)) begin
                        col_nxt = '0;
                        row_nxt = row_inc;
                    end else begin
                        col_nxt = CURSOR_COL + COL_W'(1);
                    end
                end
            end
            ST_CLR_WR: begin
                // AVM_ADDR doubles as the clear word counter.
                if (!AVM_WAITREQUEST) begin
                    if (AVM_ADDR == ADDR_W'(VRAM_WORDS - 1)) begin
                        state_nxt = ST_CTRL_WR;
                        addr_nxt  = ADDR_W'(CTRL_ADDR);
                        wdata_nxt = CTRL_INIT;
                    end else begin
                        addr_nxt = AVM_ADDR + ADDR_W'(1);
                    end
                end
            end
            ST_CTRL_WR: begin
                if (!AVM_WAITREQUEST) begin
                    state_nxt = ST_IDLE;
                    write_nxt = 1'b0;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= ST_IDLE;
            BUSY          <= 1'b0;
            CURSOR_COL    <= '0;
            CURSOR_ROW    <= '0;
            AVM_ADDR      <= '0;
            AVM_WRITE     <= 1'b0;
            AVM_BYTE_EN   <= '0;
            AVM_WRITEDATA <= '0;
        end else begin
            state         <= state_nxt;
            BUSY          <= (state_nxt != ST_IDLE);
            CURSOR_COL    <= col_nxt;
            CURSOR_ROW    <= row_nxt;
            AVM_ADDR      <= addr_nxt;
            AVM_WRITE     <= write_nxt;
            AVM_BYTE_EN   <= be_nxt;
            AVM_WRITEDATA <= wdata_nxt;
        end
    end
endmodule

// File: tb/tb_vga_text_console_writer.sv
// Scoreboard bench for vga_text_console_writer: a cursor model predicts each VRAM write,
// a negedge monitor compares completed bus writes against the queue.
module tb_vga_text_console_writer;
    typedef struct packed {
        logic [9:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  CHAR_IN = 8'h00;
    logic        CHAR_INV = 1'b0;
    logic        CHAR_VALID = 1'b0;
    logic        CHAR_READY;
    logic        CLEAR_REQ = 1'b0;
    logic        BUSY;
    logic [6:0]  CURSOR_COL;
    logic [4:0]  CURSOR_ROW;
    logic [9:0]  AVM_ADDR;
    logic        AVM_CS;
    logic        AVM_WRITE;
    logic [3:0]  AVM_BYTE_EN;
    logic [31:0] AVM_WRITEDATA;
    logic        AVM_WAITREQUEST = 1'b0;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  mcol = 0;
    int  mrow = 0;
    int  wr_cycles = 0;
    bit  rand_wait = 1'b0;

    vga_text_console_writer dut (
        .CLK(CLK), .RESET(RESET),
        .CHAR_IN(CHAR_IN), .CHAR_INV(CHAR_INV), .CHAR_VALID(CHAR_VALID), .CHAR_READY(CHAR_READY),
        .CLEAR_REQ(CLEAR_REQ), .BUSY(BUSY), .CURSOR_COL(CURSOR_COL), .CURSOR_ROW(CURSOR_ROW),
        .AVM_ADDR(AVM_ADDR), .AVM_CS(AVM_CS), .AVM_WRITE(AVM_WRITE), .AVM_BYTE_EN(AVM_BYTE_EN),
        .AVM_WRITEDATA(AVM_WRITEDATA), .AVM_WAITREQUEST(AVM_WAITREQUEST)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Completed writes are those seen with WRITE=1 and WAITREQUEST=0 ahead of the next rising edge.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (AVM_WRITE) wr_cycles++;
            if (AVM_WRITE && !AVM_WAITREQUEST) begin
                check("cs_eq_write", 64'(AVM_CS), 64'(1));
                if (sb.size() == 0) begin
                    check("unexpected_write", 64'(AVM_ADDR), 64'h3FF_FFFF);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("wr_addr", 64'(AVM_ADDR), 64'(e.a));
                    check("wr_be", 64'(AVM_BYTE_EN), 64'(e.be));
                    check("wr_data", 64'(AVM_WRITEDATA), 64'(e.d));
                end
            end
        end
    end

    always @(posedge CLK) begin
        if (rand_wait) begin
            #1 AVM_WAITREQUEST = 1'($urandom_range(0, 1));
        end
    end

    function automatic int next_row(input int r);
        return (r == 29) ? 0 : r + 1;
    endfunction

    task automatic model_char(input logic [7:0] c, input logic inv);
        wr_t e;
        int  idx;
        case (c)
            8'h0A: begin mcol = 0; mrow = next_row(mrow); end
            8'h0D: mcol = 0;
            8'h08: if (mcol > 0) mcol = mcol - 1;
            default: begin
                idx  = mrow * 80 + mcol;
                e.a  = 10'(idx / 4);
                e.be = 4'(1 << (idx % 4));
                e.d  = {4{inv, c[6:0]}};
                sb.push_back(e);
                if (mcol == 79) begin mcol = 0; mrow = next_row(mrow); end
                else mcol = mcol + 1;
            end
        endcase
    endtask

    task automatic send_char(input logic [7:0] c, input logic inv);
        int n = 0;
        while (!CHAR_READY && n < 2000) begin
            @(posedge CLK); #1;
            n++;
        end
        check("ready_timeout", 64'(CHAR_READY), 64'(1));
        CHAR_IN = c;
        CHAR_INV = inv;
        CHAR_VALID = 1'b1;
        model_char(c, inv);
        @(posedge CLK); #1;
        CHAR_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge CLK);
        while (BUSY && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_idle"}, 64'(BUSY), 64'(0));
        check({tag, "_col"}, 64'(CURSOR_COL), 64'(mcol));
        check({tag, "_row"}, 64'(CURSOR_ROW), 64'(mrow));
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    endtask

    task automatic start_clear();
        wr_t e;
        CLEAR_REQ = 1'b1;
        CHAR_IN = 8'h58;
        CHAR_VALID = 1'b1;
        #1;
        check("ready_vs_clear", 64'(CHAR_READY), 64'(0));
        for (int k = 0; k < 600; k++) begin
            e.a = 10'(k); e.be = 4'hF; e.d = 32'h0;
            sb.push_back(e);
        end
        e.a = 10'd600; e.be = 4'hF; e.d = 32'h01E00000;
        sb.push_back(e);
        mcol = 0;
        mrow = 0;
        @(posedge CLK); #1;
        CLEAR_REQ = 1'b0;
        CHAR_VALID = 1'b0;
    endtask

    initial begin
        int pc;
        int pr;
        int n;
        logic [7:0] c;

        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        check("rst_write", 64'(AVM_WRITE), 64'(0));
        check("rst_cs", 64'(AVM_CS), 64'(0));
        check("rst_addr", 64'(AVM_ADDR), 64'(0));
        check("rst_be", 64'(AVM_BYTE_EN), 64'(0));
        check("rst_wdata", 64'(AVM_WRITEDATA), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_cursor", 64'({CURSOR_ROW, CURSOR_COL}), 64'(0));
        RESET = 1'b0;

        // 'A' at origin, then 0xC2 inverted in lane 3
        send_char(8'h41, 1'b0);
        wait_idle("t1");
        send_char(8'h42, 1'b0);
        send_char(8'h43, 1'b0);
        send_char(8'hC2, 1'b1);
        wait_idle("t2");

        // Last cell wraps the cursor home; LF on the last row wraps too
        send_char(8'h0D, 1'b0);
        for (int i = 0; i < 29; i++) send_char(8'h0A, 1'b0);
        for (int i = 0; i < 79; i++) send_char(8'h61 + 8'(i % 26), 1'b0);
        wait_idle("t3a");
        send_char(8'h5A, 1'b0);
        wait_idle("t3b");
        for (int i = 0; i < 29; i++) send_char(8'h0A, 1'b0);
        for (int i = 0; i < 5; i++) send_char(8'h30 + 8'(i), 1'b0);
        send_char(8'h08, 1'b0);
        send_char(8'h39, 1'b1);
        wait_idle("t3c");
        send_char(8'h0A, 1'b0);
        wait_idle("t3d");
        send_char(8'h08, 1'b0);
        wait_idle("t3e");

        // Stalled write holds the bus; CLEAR_REQ outside IDLE is ignored
        AVM_WAITREQUEST = 1'b1;
        pc = mcol;
        pr = mrow;
        send_char(8'h51, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (i == 1) CLEAR_REQ = 1'b1;
            if (i == 3) CLEAR_REQ = 1'b0;
            if (sb.size() == 0) begin
                check("stall_sb", 64'(0), 64'(1));
            end else begin
                check("stall_addr", 64'(AVM_ADDR), 64'(sb[0].a));
                check("stall_be", 64'(AVM_BYTE_EN), 64'(sb[0].be));
                check("stall_data", 64'(AVM_WRITEDATA), 64'(sb[0].d));
            end
            check("stall_write", 64'(AVM_WRITE), 64'(1));
            check("stall_ready", 64'(CHAR_READY), 64'(0));
            check("stall_cursor", 64'({CURSOR_ROW, CURSOR_COL}), 64'({5'(pr), 7'(pc)}));
        end
        AVM_WAITREQUEST = 1'b0;
        wait_idle("t4");

        // Random stream with random wait states
        rand_wait = 1'b1;
        for (int i = 0; i < 60; i++) begin
            n = int'($urandom_range(0, 7));
            c = (n == 0) ? 8'h0A : (n == 1) ? 8'h0D : (n == 2) ? 8'h08 : 8'($urandom_range(32, 255));
            send_char(c, 1'($urandom_range(0, 1)));
        end
        rand_wait = 1'b0;
        @(posedge CLK);
        #2 AVM_WAITREQUEST = 1'b0;
        wait_idle("trand");

        // Clear beats a simultaneous character; 601 back-to-back writes
        send_char(8'h21, 1'b0);
        wait_idle("t5pre");
        wr_cycles = 0;
        start_clear();
        wait_idle("t5");
        check("clear_cycles", 64'(wr_cycles), 64'(601));

        // Reset mid-clear aborts immediately
        send_char(8'h22, 1'b0);
        send_char(8'h23, 1'b0);
        wait_idle("t6pre");
        start_clear();
        n = 0;
        @(negedge CLK);
        while (!(AVM_WRITE && AVM_ADDR == 10'd300) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("t6_reach300", 64'(AVM_ADDR), 64'(300));
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("t6_write", 64'(AVM_WRITE), 64'(0));
        check("t6_busy", 64'(BUSY), 64'(0));
        check("t6_cursor", 64'({CURSOR_ROW, CURSOR_COL}), 64'(0));
        sb.delete();
        mcol = 0;
        mrow = 0;
        RESET = 1'b0;
        send_char(8'h41, 1'b0);
        wait_idle("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
